// File: rtl/otter_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : otter_fetch_queue
//  Description : Instruction-fetch front end for the pipelined OTTER.
//                Issues reads on the synchronous instruction port of Memory,
//                buffers up to DEPTH fetched instructions and presents them
//                to decode first-word-fall-through with a valid/ready
//                handshake. REDIRECT flushes the queue and restarts fetch at
//                a new PC in the same cycle.
//  Ports       : CLK, RST (sync, active-high)
//                REDIRECT / REDIRECT_PC        - flush and restart fetch
//                MEM_RDEN1 / MEM_ADDR1 / MEM_DOUT1 - instruction port
//                ID_VALID / ID_READY / ID_INSTR / ID_PC / ID_NPC - decode side
//                COUNT                          - queue occupancy
//  Options     : OTTER_FETCH_BYPASS_EN - when defined, a response arriving at
//                an empty queue is presented to decode in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module otter_fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter int          ADDR_W    = 14,
    parameter logic [31:0] RESET_VEC = 32'h0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       REDIRECT,
    input  logic [31:0]                REDIRECT_PC,
    output logic                       MEM_RDEN1,
    output logic [ADDR_W-1:0]          MEM_ADDR1,
    input  logic [31:0]                MEM_DOUT1,
    output logic                       ID_VALID,
    input  logic                       ID_READY,
    output logic [31:0]                ID_INSTR,
    output logic [31:0]                ID_PC,
    output logic [31:0]                ID_NPC,
    output logic [$clog2(DEPTH+1)-1:0] COUNT
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    logic [31:0]        r_fpc;
    logic               r_inflight;
    logic [31:0]        r_ipc;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [31:0]        r_instr [DEPTH];
    logic [31:0]        r_pc    [DEPTH];

    logic [31:0]        w_redir_pc;
    logic [31:0]        w_issue_pc;
    logic [c_CNT_W:0]   w_occ;
    logic               w_issue;
    logic               w_resp;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;

    assign w_empty    = (r_count == '0);
    assign w_redir_pc = REDIRECT_PC & ~32'd3;
    assign w_issue_pc = REDIRECT ? w_redir_pc : r_fpc;

    // Credit check counts the outstanding read so a response always has a slot.
    assign w_occ      = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_inflight};
    assign w_issue    = !RST && (REDIRECT || (w_occ < (c_CNT_W+1)'(DEPTH)));

    assign MEM_RDEN1  = w_issue;
    assign MEM_ADDR1  = w_issue_pc[ADDR_W+1:2];

    // A response landing in a redirect (or reset) cycle belongs to the old path.
    assign w_resp     = r_inflight && !REDIRECT && !RST;
    assign w_pop      = !w_empty && ID_READY && !REDIRECT;

`ifdef OTTER_FETCH_BYPASS_EN
    logic w_byp;
    assign w_byp    = w_resp && w_empty;
    assign ID_VALID = !w_empty || w_byp;
    assign ID_INSTR = w_empty ? MEM_DOUT1 : r_instr[r_rd_ptr];
    assign ID_PC    = w_empty ? r_ipc     : r_pc[r_rd_ptr];
    // A bypassed instruction taken by decode is never stored.
    assign w_push   = w_resp && !(w_byp && ID_READY);
`else
    assign ID_VALID = !w_empty;
    assign ID_INSTR = r_instr[r_rd_ptr];
    assign ID_PC    = r_pc[r_rd_ptr];
    assign w_push   = w_resp;
`endif

    assign ID_NPC = ID_PC + 32'd4;
    assign COUNT  = r_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fpc      <= RESET_VEC;
            r_inflight <= 1'b0;
            r_ipc      <= RESET_VEC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (REDIRECT) begin
            r_fpc      <= w_redir_pc + 32'd4;
            r_inflight <= 1'b1;
            r_ipc      <= w_redir_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fpc <= w_issue_pc + 32'd4;
                r_ipc <= w_issue_pc;
            end
            if (w_push) begin
                r_instr[r_wr_ptr] <= MEM_DOUT1;
                r_pc[r_wr_ptr]    <= r_ipc;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(w_push && (r_count == c_CNT_W'(DEPTH))));

endmodule
`default_nettype wire
